// File: rtl/pc_fetch_pkg.sv
// Shared constants and types for the pc_fetch instruction fetch front-end.
// The optional same-cycle response bypass is enabled by defining PC_FETCH_BYPASS_EN.
package pc_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pair_t;
endpackage

// File: rtl/pc_fetch_if.sv
// Bundle of pipeline-control, instruction-memory and IF/ID signals around pc_fetch.
// master = the fetch unit, slave = memory plus pipeline control / IF/ID side.
interface pc_fetch_if;
  import pc_fetch_pkg::*;

  // imem handshake: a request transfers on a cycle with imem_req_o && imem_gnt_i;
  // imem_addr_o must stay stable while imem_req_o && !imem_gnt_i. Responses come back
  // in request order with imem_rvalid_i, at least one cycle after their grant.
  logic            stall_i;
  logic            flush_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            valid_o;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] inst_o;

  modport master (
    input  stall_i, flush_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, valid_o, pc_o, inst_o
  );

  modport slave (
    output stall_i, flush_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, valid_o, pc_o, inst_o
  );
endinterface

// File: rtl/pc_fetch_fifo.sv
// Small circular buffer of {pc, inst} pairs; flush empties it in one cycle.
module pc_fetch_fifo
  import pc_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        push_i,
  input  fetch_pair_t din_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output fetch_pair_t head_o,
  output logic [CW-1:0] count_o,
  output logic        empty_o
);
  fetch_pair_t   mem_q [DEPTH];
  fetch_pair_t   mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      // When full, a push is only legal alongside a pop, so writing the head slot is safe.
      if (push_i) begin
        mem_d[wr_q] = din_i;
        wr_d        = wr_q + AW'(1);
      end
      if (pop_i) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch front-end: owns the PC, issues credit-limited imem requests,
// buffers {pc, inst} responses and drops stale ones after a flush. Optional PC_FETCH_BYPASS_EN.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  pc_fetch_if.master bus
);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;

  fetch_pair_t   head, out_pair, push_pair;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_push, fifo_pop;
  logic          resp_take, bypass, valid, pop, req, gnt_fire;
  logic [CW:0]   credit_used;

  pc_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (fifo_push),
    .din_i   (push_pair),
    .pop_i   (fifo_pop),
    .flush_i (bus.flush_i),
    .head_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_comb begin
    resp_take = bus.imem_rvalid_i && (drop_q == '0);
    push_pair = '{pc: resp_pc_q, inst: bus.imem_rdata_i};
`ifdef PC_FETCH_BYPASS_EN
    bypass = fifo_empty && resp_take && !bus.flush_i;
`else
    bypass = 1'b0;
`endif
    valid    = rst_n_i && (!fifo_empty || bypass);
    out_pair = bypass ? push_pair : head;
    pop      = valid && !bus.stall_i;

    // Dropped responses still occupy the memory pipe, so they consume credits too;
    // this keeps every counter within DEPTH even across back-to-back flushes.
    credit_used = {1'b0, outst_q} + {1'b0, drop_q} + {1'b0, fifo_count} - (CW+1)'(pop);
    req         = rst_n_i && !bus.flush_i && (credit_used < (CW+1)'(DEPTH));
    gnt_fire    = req && bus.imem_gnt_i;

    fifo_push = !bus.flush_i && resp_take && !(bypass && pop);
    fifo_pop  = !bus.flush_i && pop && !bypass;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (bus.flush_i) begin
      // Everything in flight becomes stale; the next kept response belongs to redirect_pc.
      fetch_pc_d = bus.redirect_pc_i;
      resp_pc_d  = bus.redirect_pc_i;
      outst_d    = '0;
      drop_d     = outst_q + drop_q - CW'(bus.imem_rvalid_i);
    end else begin
      if (gnt_fire)  fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_take) resp_pc_d  = resp_pc_q + XLEN'(4);
      outst_d = outst_q + CW'(gnt_fire) - CW'(resp_take);
      drop_d  = drop_q - CW'(bus.imem_rvalid_i && (drop_q != '0));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = fetch_pc_q;
  assign bus.valid_o     = valid;
  assign bus.pc_o        = valid ? out_pair.pc   : '0;
  assign bus.inst_o      = valid ? out_pair.inst : INST_NOP;
endmodule
